// File: rtl/piece_pkg.sv
// Tetromino shape/colour tables and shared types for the piece row streamer.
// Shape rows are nibbles with the MSB at piece-grid column 0.
package piece_pkg;

  typedef enum logic [2:0] {
    PIECE_I, PIECE_J, PIECE_L, PIECE_O, PIECE_S, PIECE_T, PIECE_Z, PIECE_NONE
  } piece_id_t;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

  typedef struct packed {
    piece_id_t  id;
    logic [1:0] rot;
  } piece_key_t;

  // [id][rot][row]
  localparam logic [3:0] SHAPE_TAB [8][4][4] = '{
    '{'{4'hF,4'h0,4'h0,4'h0}, '{4'h2,4'h2,4'h2,4'h2}, '{4'hF,4'h0,4'h0,4'h0}, '{4'h2,4'h2,4'h2,4'h2}},
    '{'{4'h4,4'h7,4'h0,4'h0}, '{4'h2,4'h2,4'h6,4'h0}, '{4'h0,4'h7,4'h1,4'h0}, '{4'h3,4'h2,4'h2,4'h0}},
    '{'{4'h1,4'h7,4'h0,4'h0}, '{4'h6,4'h2,4'h2,4'h0}, '{4'h0,4'h7,4'h4,4'h0}, '{4'h2,4'h2,4'h3,4'h0}},
    '{'{4'h6,4'h6,4'h0,4'h0}, '{4'h6,4'h6,4'h0,4'h0}, '{4'h6,4'h6,4'h0,4'h0}, '{4'h6,4'h6,4'h0,4'h0}},
    '{'{4'h3,4'h6,4'h0,4'h0}, '{4'h4,4'h6,4'h2,4'h0}, '{4'h3,4'h6,4'h0,4'h0}, '{4'h4,4'h6,4'h2,4'h0}},
    '{'{4'h2,4'h7,4'h0,4'h0}, '{4'h2,4'h6,4'h2,4'h0}, '{4'h0,4'h7,4'h2,4'h0}, '{4'h2,4'h3,4'h2,4'h0}},
    '{'{4'h6,4'h3,4'h0,4'h0}, '{4'h1,4'h3,4'h2,4'h0}, '{4'h6,4'h3,4'h0,4'h0}, '{4'h1,4'h3,4'h2,4'h0}},
    '{'{4'h0,4'h0,4'h0,4'h0}, '{4'h0,4'h0,4'h0,4'h0}, '{4'h0,4'h0,4'h0,4'h0}, '{4'h0,4'h0,4'h0,4'h0}}
  };

  localparam logic [2:0] COLOUR_TAB [8] = '{3'd3, 3'd1, 3'd7, 3'd6, 3'd2, 3'd5, 3'd4, 3'd0};

  // Bit k set when grid row k of the shape has any occupied cell.
  function automatic logic [3:0] row_mask(piece_id_t id, logic [1:0] rot);
    row_mask = 4'h0;
    for (int k = 0; k < 4; k++) row_mask[k] = |SHAPE_TAB[id][rot][k];
  endfunction

endpackage

// File: rtl/piece_row_streamer_if.sv
// Request and row-stream bundle between game controller, streamer and board logic.
// master = controller/board side, slave = streamer.
interface piece_row_streamer_if #(
  parameter int BOARD_W = 10,
  parameter int XW      = 5,
  parameter int YW      = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_id;
  logic [1:0]            req_rot;
  logic signed [XW-1:0]  req_x;
  logic signed [YW-1:0]  req_y;
  logic                  out_valid;
  logic                  out_ready;
  logic [BOARD_W-1:0]    out_row;
  logic signed [YW-1:0]  out_y;
  logic [2:0]            out_rgb;
  logic                  out_last;
  logic                  done;
  logic                  oob_left;
  logic                  oob_right;
  logic                  oob_bottom;

  modport master (
    output req_valid, req_id, req_rot, req_x, req_y, out_ready,
    input  req_ready, out_valid, out_row, out_y, out_rgb, out_last,
           done, oob_left, oob_right, oob_bottom
  );

  modport slave (
    input  req_valid, req_id, req_rot, req_x, req_y, out_ready,
    output req_ready, out_valid, out_row, out_y, out_rgb, out_last,
           done, oob_left, oob_right, oob_bottom
  );
endinterface

// File: rtl/piece_shape_lookup.sv
// Combinational (id, rot, row) -> shape nibble and colour.
// Latency: 0 cycles. Backpressure: none (pure lookup).
module piece_shape_lookup
  import piece_pkg::*;
(
  input  piece_id_t  id,
  input  logic [1:0] rot,
  input  logic [1:0] row,
  output logic [3:0] bits,
  output logic [2:0] rgb
);
  assign bits = SHAPE_TAB[id][rot][row];
  assign rgb  = COLOUR_TAB[id];
endmodule

// File: rtl/piece_row_streamer.sv
// Streams a piece's rows as board-aligned bitmaps, then pulses done with oob flags.
// Latency: first row 1 cycle after accept; outputs held while out_valid && !out_ready.
// PIECE_STREAM_SKIP_EMPTY_EN: skip all-zero grid rows (empty piece goes straight to done).
module piece_row_streamer
  import piece_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int XW      = 5,
  parameter int YW      = 6
) (
  input  logic               clk,
  input  logic               reset,
  piece_row_streamer_if.slave bus
);
  localparam int W = ((XW > YW) ? XW : YW) + 1;

  state_t               state;
  piece_key_t           lat_key, sel_key;
  logic signed [XW-1:0] lat_x, sel_x;
  logic signed [YW-1:0] lat_y, sel_y;
  logic [1:0]           idx, nidx, first_idx, last_idx, next_idx;
  logic [3:0]           mask, grid_bits;
  logic [2:0]           grid_rgb;
  logic                 accept, hs, load;
  logic [BOARD_W-1:0]   row_bits;
  logic                 row_l, row_r, row_b;
  logic                 cur_l, cur_r, cur_b;
  logic signed [W-1:0]  brow;

  assign accept = (state == ST_IDLE) && bus.req_valid;
  assign hs     = (state == ST_STREAM) && bus.out_valid && bus.out_ready;
  assign load   = (accept && (mask != 4'h0)) || (hs && !bus.out_last);

  // On the accept cycle look at the incoming request so the first row can be registered.
  always_comb begin
    sel_key = lat_key;
    sel_x   = lat_x;
    sel_y   = lat_y;
    if (accept) begin
      sel_key = '{id: piece_id_t'(bus.req_id), rot: bus.req_rot};
      sel_x   = bus.req_x;
      sel_y   = bus.req_y;
    end
  end

`ifdef PIECE_STREAM_SKIP_EMPTY_EN
  assign mask = row_mask(sel_key.id, sel_key.rot);
`else
  assign mask = 4'hF;
`endif

  always_comb begin
    first_idx = 2'd0;
    last_idx  = 2'd0;
    next_idx  = idx;
    for (int k = 3; k >= 0; k--) if (mask[k]) first_idx = 2'(k);
    for (int k = 0; k < 4; k++) if (mask[k]) last_idx = 2'(k);
    for (int k = 3; k >= 0; k--) if (mask[k] && (2'(k) > idx)) next_idx = 2'(k);
    nidx = accept ? first_idx : next_idx;
  end

  piece_shape_lookup u_lookup (
    .id  (sel_key.id),
    .rot (sel_key.rot),
    .row (nidx),
    .bits(grid_bits),
    .rgb (grid_rgb)
  );

  // Off-board columns are dropped and flagged; rows below the board are still emitted.
  always_comb begin
    logic signed [W-1:0] col;
    row_bits = '0;
    row_l    = 1'b0;
    row_r    = 1'b0;
    row_b    = 1'b0;
    col      = '0;
    brow     = W'(sel_y) + W'(nidx);
    for (int j = 0; j < 4; j++) begin
      if (grid_bits[3-j]) begin
        col = W'(sel_x) + W'(j);
        if (brow >= BOARD_H) row_b = 1'b1;
        if (col < 0) row_l = 1'b1;
        else if (col >= BOARD_W) row_r = 1'b1;
        else for (int c = 0; c < BOARD_W; c++) if (col == c) row_bits[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      lat_key        <= '0;
      lat_x          <= '0;
      lat_y          <= '0;
      idx            <= '0;
      cur_l          <= 1'b0;
      cur_r          <= 1'b0;
      cur_b          <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_row    <= '0;
      bus.out_y      <= '0;
      bus.out_rgb    <= '0;
      bus.out_last   <= 1'b0;
      bus.done       <= 1'b0;
      bus.oob_left   <= 1'b0;
      bus.oob_right  <= 1'b0;
      bus.oob_bottom <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_key        <= sel_key;
            lat_x          <= sel_x;
            lat_y          <= sel_y;
            bus.req_ready  <= 1'b0;
            bus.oob_left   <= 1'b0;
            bus.oob_right  <= 1'b0;
            bus.oob_bottom <= 1'b0;
            if (mask == 4'h0) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (hs) begin
            bus.oob_left   <= bus.oob_left   | cur_l;
            bus.oob_right  <= bus.oob_right  | cur_r;
            bus.oob_bottom <= bus.oob_bottom | cur_b;
            if (bus.out_last) begin
              state         <= ST_DONE;
              bus.done      <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (load) begin
        idx           <= nidx;
        bus.out_valid <= 1'b1;
        bus.out_row   <= row_bits;
        bus.out_y     <= YW'(brow);
        bus.out_rgb   <= grid_rgb;
        bus.out_last  <= (nidx == last_idx);
        cur_l         <= row_l;
        cur_r         <= row_r;
        cur_b         <= row_b;
      end
    end
  end
endmodule
